// File: rtl/mux2_arb_pkg.sv
// Shared types and select encodings for the two-requester MUX2 round-robin arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_hold_counter.sv
// Grant-tenure counter: synchronous clear, enabled saturating increment, limit flag.
module mux2_hold_counter #(
    parameter int CNT_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             CLK,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_limit_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_limit_o = (cnt_q == LIMIT);
    assign cnt_o      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !at_limit_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared MUX2: registered one-hot grants, bubble-free
// handoff between A and B, tenure bounded by MAX_HOLD while the other side waits.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_A,
    input  logic REQ_B,
    input  logic REL_A,
    input  logic REL_B,
    output logic GNT_A,
    output logic GNT_B,
    output logic S,
    output logic BUSY,
    output logic SWITCH
);

    state_t state_q, state_d;
    side_t  last_q, last_d;
    logic   gnt_a_q, gnt_b_q, s_q, s_d, busy_q, switch_q, switch_d;
    logic   cnt_clr, cnt_en, at_limit;
    logic   rel, pre, other_req;
    logic [CNT_W-1:0] cnt;

    mux2_hold_counter #(
        .CNT_W   (CNT_W),
        .MAX_HOLD(MAX_HOLD)
    ) u_hold (
        .CLK       (CLK),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .cnt_o     (cnt),
        .at_limit_o(at_limit)
    );

    // Counter restarts on any ownership change; it only advances while tenure continues.
    assign cnt_clr = RST || (state_d != state_q) || (state_q == IDLE);
    assign cnt_en  = !cnt_clr;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        s_d       = s_q;
        switch_d  = 1'b0;
        rel       = 1'b0;
        pre       = 1'b0;
        other_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (REQ_A && REQ_B)
                    state_d = (last_q == SIDE_B) ? OWN_A : OWN_B;
                else if (REQ_A)
                    state_d = OWN_A;
                else if (REQ_B)
                    state_d = OWN_B;
            end
            OWN_A: begin
                rel       = REL_A || !REQ_A;
                other_req = REQ_B;
                pre       = REQ_B && at_limit;
                if ((rel || pre) && other_req) begin
                    state_d  = OWN_B;
                    switch_d = 1'b1;
                end else if (rel) begin
                    state_d = IDLE;
                end
            end
            OWN_B: begin
                rel       = REL_B || !REQ_B;
                other_req = REQ_A;
                pre       = REQ_A && at_limit;
                if ((rel || pre) && other_req) begin
                    state_d  = OWN_A;
                    switch_d = 1'b1;
                end else if (rel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // S only moves when someone takes ownership, so IDLE keeps the mux steady.
        if (state_d == OWN_A) begin
            s_d    = SEL_A;
            last_d = SIDE_A;
        end else if (state_d == OWN_B) begin
            s_d    = SEL_B;
            last_d = SIDE_B;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            last_q   <= SIDE_B;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            s_q      <= SEL_A;
            busy_q   <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_a_q  <= (state_d == OWN_A);
            gnt_b_q  <= (state_d == OWN_B);
            s_q      <= s_d;
            busy_q   <= (state_d != IDLE);
            switch_q <= switch_d;
        end
    end

    assign GNT_A  = gnt_a_q;
    assign GNT_B  = gnt_b_q;
    assign S      = s_q;
    assign BUSY   = busy_q;
    assign SWITCH = switch_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (MAX_HOLD=8); outputs checked as {GNT_A,GNT_B,S,BUSY,SWITCH}.
module tb_mux2_rr_arbiter;

    logic CLK = 1'b0;
    logic RST, REQ_A, REQ_B, REL_A, REL_B;
    logic GNT_A, GNT_B, S, BUSY, SWITCH;
    int   n_chk = 0;
    int   n_err = 0;

    mux2_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ_A (REQ_A),
        .REQ_B (REQ_B),
        .REL_A (REL_A),
        .REL_B (REL_B),
        .GNT_A (GNT_A),
        .GNT_B (GNT_B),
        .S     (S),
        .BUSY  (BUSY),
        .SWITCH(SWITCH)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got gnt_a,gnt_b,s,busy,switch=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {GNT_A, GNT_B, S, BUSY, SWITCH};
    endfunction

    initial begin
        RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1; REL_A = 1'b0; REL_B = 1'b0;
        step(); chk("reset1", outs(), 5'b00000);
        step(); chk("reset2", outs(), 5'b00000);

        // First tie after reset goes to A.
        RST = 1'b0;
        step(); chk("first_tie_A", outs(), 5'b10010);

        REQ_A = 1'b0; REQ_B = 1'b0;
        step(); chk("idle_S_hold0", outs(), 5'b00000);

        REQ_B = 1'b1;
        step(); chk("grant_B", outs(), 5'b01110);
        step(); chk("hold_B1", outs(), 5'b01110);
        step(); chk("hold_B2", outs(), 5'b01110);

        REL_B = 1'b1;
        step(); chk("rel_B_idle_S1", outs(), 5'b00100);
        REL_B = 1'b0; REQ_B = 1'b0;
        step(); chk("idle_stay", outs(), 5'b00100);

        // REL_A while A is not granted must not disturb B.
        REQ_B = 1'b1; REL_A = 1'b1;
        step(); chk("relA_ign_idle", outs(), 5'b01110);
        step(); chk("relA_ign_ownB", outs(), 5'b01110);
        REL_A = 1'b0; REQ_B = 1'b0;
        step(); chk("ownB_drop", outs(), 5'b00100);

        // Continuous contention: 8-cycle tenures, SWITCH on each handoff.
        REQ_A = 1'b1; REQ_B = 1'b1;
        step(); chk("cont_enter_A", outs(), 5'b10010);
        for (int i = 0; i < 7; i++) begin
            step(); chk($sformatf("cont_A%0d", i + 1), outs(), 5'b10010);
        end
        step(); chk("cont_sw_B", outs(), 5'b01111);
        for (int i = 0; i < 7; i++) begin
            step(); chk($sformatf("cont_B%0d", i + 1), outs(), 5'b01110);
        end
        step(); chk("cont_sw_A", outs(), 5'b10011);

        // Early release at cnt=3 hands off straight to B.
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("pre_rel_A%0d", i + 1), outs(), 5'b10010);
        end
        REL_A = 1'b1;
        step(); chk("rel_A_handoff", outs(), 5'b01111);
        REL_A = 1'b0;

        // B drops with A waiting, then A holds alone well past MAX_HOLD.
        REQ_B = 1'b0;
        step(); chk("dropB_to_A", outs(), 5'b10011);
        for (int i = 0; i < 20; i++) begin
            step(); chk($sformatf("sat_A%0d", i), outs(), 5'b10010);
        end
        REQ_B = 1'b1;
        step(); chk("sat_preempt_B", outs(), 5'b01111);

        // Reset mid-grant at cnt=4.
        for (int i = 0; i < 4; i++) begin
            step(); chk($sformatf("rst_prep_B%0d", i + 1), outs(), 5'b01110);
        end
        RST = 1'b1;
        step(); chk("rst_mid_grant", outs(), 5'b00000);
        RST = 1'b0;
        step(); chk("post_rst_A", outs(), 5'b10010);

        REQ_A = 1'b0; REQ_B = 1'b0;
        step(); chk("final_idle", outs(), 5'b00000);
        step(); chk("final_idle2", outs(), 5'b00000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Round-robin arbiter that shares one MUX2 datapath between two requesters (A, B) by driving its select line S. Grants are registered, one-hot, and handed off without idle bubbles. A hold counter bounds grant tenure so neither requester starves. Sits directly upstream of the MUX2 cell netlist; S connects to the MUX2 S pin.

Parameters:
MAX_HOLD, 8, max consecutive granted cycles while the other side is requesting; legal range 1..2**CNT_W
CNT_W, 4, hold counter width; must satisfy 2**CNT_W >= MAX_HOLD

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-high
REQ_A  input  1  requester A wants the datapath (level)
REQ_B  input  1  requester B wants the datapath (level)
REL_A  input  1  A releases voluntarily (1-cycle pulse, honoured only while GNT_A=1)
REL_B  input  1  B releases voluntarily (1-cycle pulse, honoured only while GNT_B=1)
GNT_A  output  1  A owns the datapath (registered)
GNT_B  output  1  B owns the datapath (registered)
S  output  1  MUX2 select: 0 = A path, 1 = B path (registered)
BUSY  output  1  GNT_A | GNT_B (registered)
SWITCH  output  1  1-cycle pulse on the cycle a grant moves directly A->B or B->A

Behaviour:
- Clock/reset: one clock CLK; RST is synchronous and active-high. Sampled only on the rising edge of CLK; RST dominates all other inputs.
- Reset values: state=IDLE, GNT_A=0, GNT_B=0, S=0, BUSY=0, SWITCH=0, cnt=0, last=B (A wins the first tie).
- Reset mid-grant: the grant drops at the next edge; no handoff occurs and SWITCH stays 0.
- States: IDLE, OWN_A, OWN_B. All outputs are registered; request-to-grant latency is 1 cycle.
- IDLE:
  - REQ_A&REQ_B -> grant the side != last.
  - Only REQ_A -> OWN_A. Only REQ_B -> OWN_B. Neither -> stay IDLE.
  - S holds its previous value in IDLE so the mux output does not toggle needlessly.
- On entering OWN_X: GNT_X=1, S=SEL_X, cnt=0, last=X.
- Release condition in OWN_X (rel): REL_X=1 or REQ_X=0.
- Preempt condition in OWN_X (pre): REQ_other=1 and cnt==MAX_HOLD-1.
- OWN_X, rel or pre, other requesting: move directly to OWN_other at the same edge.
  - GNT_X falls, GNT_other rises, S flips, SWITCH=1 for one cycle, cnt=0.
- OWN_X, rel, other idle: go to IDLE with GNT=0. S holds.
- OWN_X, neither rel nor pre: stay in OWN_X; cnt increments, saturating at MAX_HOLD-1.
  - If the other side is idle, X may hold indefinitely.
- Simultaneous rel and pre: treated as a single handoff.
- REL_X while not granted: ignored.
- MAX_HOLD=1: under continuous contention, ownership alternates every cycle.
- Invariants: GNT_A&GNT_B is never 1. S==0 whenever GNT_A=1; S==1 whenever GNT_B=1. BUSY==GNT_A|GNT_B every cycle.

Decomposition:
- Package mux2_arb_pkg holds:
  - typedef state_t {IDLE, OWN_A, OWN_B}
  - constants SEL_A=1'b0, SEL_B=1'b1
  - typedef side_t {SIDE_A, SIDE_B} for the last register
- Sub-module mux2_hold_counter (CNT_W, MAX_HOLD): sync clear, enable, saturating increment, exposes at_limit.
- The FSM and output registers stay in mux2_rr_arbiter.

Test Plan:
- RST=1 for 2 cycles with REQ_A=REQ_B=1 -> all outputs 0. First cycle after RST=0: GNT_A=1, S=0, BUSY=1.
- REQ_B only at cycle 5 -> GNT_B=1 and S=1 at cycle 6. REL_B pulse at cycle 9 -> GNT_B=0 and BUSY=0 at cycle 10; S stays 1.
- MAX_HOLD=8, REQ_A=REQ_B=1 held continuously -> grants alternate A/B every 8 cycles. SWITCH pulses at each handoff; GNT_A&GNT_B never 1.
- OWN_A with REQ_B=1, REL_A at cnt=3 -> next edge GNT_B=1, S=1, SWITCH=1, cnt=0. No IDLE cycle in between.
- OWN_A for 20 cycles with REQ_B=0 -> GNT_A stays 1 and cnt saturates at 7. REQ_B rises -> GNT_B=1 one cycle later.
- RST asserted while OWN_B at cnt=4 -> next edge GNT_B=0, S=0, SWITCH=0. After release with both requesting -> A is granted first.
